writeback_stage: RTL and testbench

Final pipeline stage of the 16-bit WISC core. It owns the MEM/WB register and is the write port that drives the register file read by the decode stage (write_data, reg_wr_sel, reg_write_in). It selects the writeback source and the destination register, counts retired instructions, and runs the halt/error state machine that stops the core on a retired dump (HALT) or an upstream error.

---
 rtl/writeback_stage.sv | 168 ++++++++++++++++
 tb/tb_writeback_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Final stage of the 16-bit WISC core: MEM/WB register, register-file write port,
// retire counter and the halt/error state machine.
module writeback_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [15:0]       instr,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] pc_inc,
  input  logic [1:0]        reg_dst,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic              link,
  input  logic              dump,
  input  logic              err_in,
  output logic [DATA_W-1:0] write_data,
  output logic [REG_W-1:0]  reg_wr_sel,
  output logic              reg_write_out,
  output logic              halted,
  output logic              err,
  output logic [CNT_W-1:0]  retire_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t state_q;

  logic              wb_valid_q;
  logic [10:2]       wb_instr_q;
  logic [DATA_W-1:0] wb_alu_out_q;
  logic [DATA_W-1:0] wb_mem_data_q;
  logic [DATA_W-1:0] wb_pc_inc_q;
  logic [1:0]        wb_reg_dst_q;
  logic              wb_reg_write_q;
  logic              wb_mem_to_reg_q;
  logic              wb_link_q;
  logic              wb_dump_q;
  logic              wb_err_in_q;
  logic              halted_q;
  logic              err_q;
  logic [CNT_W-1:0]  retire_count_q;
  logic [CNT_W-1:0]  retire_count_d;

  logic cap;
  logic retire;

  // Only instr[10:2] carries register fields; the rest is decoded upstream.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[15:11], instr[1:0]};

  assign in_ready = (state_q == ST_RUN);
  assign cap      = in_valid & in_ready;
  assign retire   = cap & ~flush;

  always_comb begin
    retire_count_d = retire_count_q;
    if (retire && (retire_count_q != {CNT_W{1'b1}})) begin
      retire_count_d = retire_count_q + 1'b1;
    end
  end

  // MEM/WB register: fields only load on a real retire, bubbles just drop valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_valid_q      <= 1'b0;
      wb_instr_q      <= '0;
      wb_alu_out_q    <= '0;
      wb_mem_data_q   <= '0;
      wb_pc_inc_q     <= '0;
      wb_reg_dst_q    <= '0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_link_q       <= 1'b0;
      wb_dump_q       <= 1'b0;
      wb_err_in_q     <= 1'b0;
      retire_count_q  <= '0;
    end else begin
      wb_valid_q     <= retire;
      retire_count_q <= retire_count_d;
      if (retire) begin
        wb_instr_q      <= instr[10:2];
        wb_alu_out_q    <= alu_out;
        wb_mem_data_q   <= mem_data;
        wb_pc_inc_q     <= pc_inc;
        wb_reg_dst_q    <= reg_dst;
        wb_reg_write_q  <= reg_write;
        wb_mem_to_reg_q <= mem_to_reg;
        wb_link_q       <= link;
        wb_dump_q       <= dump;
        wb_err_in_q     <= err_in;
      end
    end
  end

  // Halt/error FSM; err_in wins over dump when both tag the same entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (retire && err_in) begin
            state_q  <= ST_ERROR;
            halted_q <= 1'b1;
            err_q    <= 1'b1;
          end else if (retire && dump) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
            err_q    <= 1'b0;
          end
        end
        ST_HALT: begin
          state_q  <= ST_HALT;
          halted_q <= 1'b1;
          err_q    <= 1'b0;
        end
        ST_ERROR: begin
          state_q  <= ST_ERROR;
          halted_q <= 1'b1;
          err_q    <= 1'b1;
        end
        default: begin
          state_q  <= ST_ERROR;
          halted_q <= 1'b1;
          err_q    <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    write_data = wb_alu_out_q;
    if (wb_link_q) begin
      write_data = wb_pc_inc_q;
    end else if (wb_mem_to_reg_q) begin
      write_data = wb_mem_data_q;
    end
  end

  always_comb begin
    reg_wr_sel = '0;
    case (wb_reg_dst_q)
      2'b00:   reg_wr_sel = wb_instr_q[4:2];
      2'b01:   reg_wr_sel = wb_instr_q[7:5];
      2'b10:   reg_wr_sel = wb_instr_q[10:8];
      default: reg_wr_sel = 3'd7;
    endcase
  end

  assign reg_write_out = wb_valid_q & wb_reg_write_q & ~wb_dump_q & ~wb_err_in_q;
  assign halted        = halted_q;
  assign err           = err_q;
  assign retire_count  = retire_count_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: expected RF writes are queued at issue and
// a negedge monitor pops them whenever the stage asserts reg_write_out.
module tb_writeback_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [15:0] instr;
  logic [15:0] alu_out;
  logic [15:0] mem_data;
  logic [15:0] pc_inc;
  logic [1:0]  reg_dst;
  logic        reg_write;
  logic        mem_to_reg;
  logic        link;
  logic        dump;
  logic        err_in;
  logic [15:0] write_data;
  logic [2:0]  reg_wr_sel;
  logic        reg_write_out;
  logic        halted;
  logic        err;
  logic [15:0] retire_count;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  sel;
    logic [15:0] cnt;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec  = 0;
  int  n_miss = 0;

  writeback_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .flush        (flush),
    .instr        (instr),
    .alu_out      (alu_out),
    .mem_data     (mem_data),
    .pc_inc       (pc_inc),
    .reg_dst      (reg_dst),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .link         (link),
    .dump         (dump),
    .err_in       (err_in),
    .write_data   (write_data),
    .reg_wr_sel   (reg_wr_sel),
    .reg_write_out(reg_write_out),
    .halted       (halted),
    .err          (err),
    .retire_count (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic expect_wr(input logic [15:0] data, input logic [2:0] sel, input logic [15:0] cnt);
    wr_t e;
    e.data = data;
    e.sel  = sel;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    in_valid = 0; flush = 0; instr = 0; alu_out = 0; mem_data = 0; pc_inc = 0;
    reg_dst = 0; reg_write = 0; mem_to_reg = 0; link = 0; dump = 0; err_in = 0;
  endtask

  // One cycle of stimulus; returns 1 time unit after the capture edge.
  task automatic send(input logic [15:0] i_instr, input logic [15:0] i_alu,
                      input logic [15:0] i_mem, input logic [15:0] i_pc,
                      input logic [1:0] i_dst, input logic i_rw, input logic i_m2r,
                      input logic i_lnk, input logic i_dmp, input logic i_err,
                      input logic i_fl);
    in_valid = 1; instr = i_instr; alu_out = i_alu; mem_data = i_mem; pc_inc = i_pc;
    reg_dst = i_dst; reg_write = i_rw; mem_to_reg = i_m2r; link = i_lnk;
    dump = i_dmp; err_in = i_err; flush = i_fl;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    rst = 0;
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  // Monitor: every RF write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reg_write_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL spurious_write: got sel=%0d data=%0h cnt=%0h expected no write",
                 reg_wr_sel, write_data, retire_count);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_data", {16'd0, write_data}, {16'd0, e.data});
        check("wr_sel", {29'd0, reg_wr_sel}, {29'd0, e.sel});
        check("wr_cnt", {16'd0, retire_count}, {16'd0, e.cnt});
      end
    end
  end

  initial begin
    idle_inputs();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_wr_en", {31'd0, reg_write_out}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_count", {16'd0, retire_count}, 32'd0);
    check("rst_wdata", {16'd0, write_data}, 32'd0);

    // Basic ALU write, instr 4123 -> instr[4:2] = 0
    expect_wr(16'hBEEF, 3'd0, 16'd1);
    send(16'h4123, 16'hBEEF, 16'h0, 16'h0, 2'b00, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("t1_no_repeat", {31'd0, reg_write_out}, 32'd0);

    // link beats mem_to_reg; then mem_to_reg beats alu
    expect_wr(16'h0042, 3'd7, 16'd2);
    send(16'h4123, 16'h9999, 16'h1234, 16'h0042, 2'b11, 1, 1, 1, 0, 0, 0);
    expect_wr(16'h1234, 3'd7, 16'd3);
    send(16'h4123, 16'h9999, 16'h1234, 16'h0042, 2'b11, 1, 1, 0, 0, 0, 0);

    // ABCD: instr[7:5] = 6, instr[10:8] = 3
    expect_wr(16'h1111, 3'd6, 16'd4);
    send(16'hABCD, 16'h1111, 16'h7777, 16'h0, 2'b01, 1, 0, 0, 0, 0, 0);
    expect_wr(16'h5A5A, 3'd3, 16'd5);
    send(16'hABCD, 16'h2222, 16'h5A5A, 16'h0, 2'b10, 1, 1, 0, 0, 0, 0);

    // Back-to-back writes to the same register, in order
    expect_wr(16'hAAAA, 3'd0, 16'd6);
    send(16'h4123, 16'hAAAA, 16'h0, 16'h0, 2'b00, 1, 0, 0, 0, 0, 0);
    expect_wr(16'h5555, 3'd0, 16'd7);
    send(16'h4123, 16'h5555, 16'h0, 16'h0, 2'b00, 1, 0, 0, 0, 0, 0);

    // Retired but non-writing entry still counts
    send(16'h4123, 16'h1, 16'h0, 16'h0, 2'b00, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("nowrite_count", {16'd0, retire_count}, 32'd8);

    // Flushed dump entry: no write, no count, no halt
    send(16'h4123, 16'h3333, 16'h0, 16'h0, 2'b00, 1, 0, 0, 1, 0, 1);
    @(negedge clk);
    check("flush_count", {16'd0, retire_count}, 32'd8);
    check("flush_halted", {31'd0, halted}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);

    // flush + err_in without in_valid does nothing
    flush = 1; err_in = 1; dump = 1;
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    check("flush_novalid_err", {31'd0, err}, 32'd0);
    check("flush_novalid_count", {16'd0, retire_count}, 32'd8);

    // Halt after three entries
    do_reset();
    expect_wr(16'h0101, 3'd0, 16'd1);
    send(16'h4123, 16'h0101, 16'h0, 16'h0, 2'b00, 1, 0, 0, 0, 0, 0);
    expect_wr(16'h0202, 3'd0, 16'd2);
    send(16'h4123, 16'h0202, 16'h0, 16'h0, 2'b00, 1, 0, 0, 0, 0, 0);
    expect_wr(16'h0303, 3'd0, 16'd3);
    send(16'h4123, 16'h0303, 16'h0, 16'h0, 2'b00, 1, 0, 0, 0, 0, 0);
    send(16'h4123, 16'h0404, 16'h0, 16'h0, 2'b00, 1, 0, 0, 1, 0, 0);
    @(negedge clk);
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_wr_en", {31'd0, reg_write_out}, 32'd0);
    check("halt_count", {16'd0, retire_count}, 32'd4);
    check("halt_in_ready", {31'd0, in_ready}, 32'd0);
    check("halt_err", {31'd0, err}, 32'd0);
    send(16'h4123, 16'h0505, 16'h0, 16'h0, 2'b00, 1, 0, 0, 0, 0, 0);
    send(16'h4123, 16'h0606, 16'h0, 16'h0, 2'b00, 1, 0, 0, 0, 1, 0);
    @(negedge clk);
    check("halt_ignored_count", {16'd0, retire_count}, 32'd4);
    check("halt_sticky", {31'd0, halted}, 32'd1);
    check("halt_no_err", {31'd0, err}, 32'd0);

    // Error with dump also set: error wins
    do_reset();
    send(16'h4123, 16'h0707, 16'h0, 16'h0, 2'b00, 1, 0, 0, 1, 1, 0);
    @(negedge clk);
    check("err_err", {31'd0, err}, 32'd1);
    check("err_halted", {31'd0, halted}, 32'd1);
    check("err_count", {16'd0, retire_count}, 32'd1);
    check("err_in_ready", {31'd0, in_ready}, 32'd0);
    do_reset();
    @(negedge clk);
    check("err_rst_err", {31'd0, err}, 32'd0);
    check("err_rst_halted", {31'd0, halted}, 32'd0);
    check("err_rst_count", {16'd0, retire_count}, 32'd0);
    check("err_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Nothing is captured while rst is low
    rst = 0;
    send(16'h4123, 16'h0808, 16'h0, 16'h0, 2'b00, 1, 0, 0, 0, 0, 0);
    rst = 1;
    @(negedge clk);
    check("rstcap_count", {16'd0, retire_count}, 32'd0);

    // Saturation
    do_reset();
    for (int i = 0; i < 65534; i++) begin
      send(16'h4123, 16'h0, 16'h0, 16'h0, 2'b00, 0, 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    check("sat_preload", {16'd0, retire_count}, 32'h0000FFFE);
    expect_wr(16'hC001, 3'd0, 16'hFFFF);
    send(16'h4123, 16'hC001, 16'h0, 16'h0, 2'b00, 1, 0, 0, 0, 0, 0);
    expect_wr(16'hC002, 3'd0, 16'hFFFF);
    send(16'h4123, 16'hC002, 16'h0, 16'h0, 2'b00, 1, 0, 0, 0, 0, 0);
    expect_wr(16'hC003, 3'd0, 16'hFFFF);
    send(16'h4123, 16'hC003, 16'h0, 16'h0, 2'b00, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("sat_hold", {16'd0, retire_count}, 32'h0000FFFF);

    // Bounded drain: every queued write must have appeared
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: got %0d writes outstanding expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
